sram_port_arbiter: RTL and testbench

Parametrised N-port arbiter in front of the single-port image SRAM, generalising the two-way busy-based JTAG/control-unit mux. Each requester (JTAG bridge, control unit, downscaler datapath lanes, ...) issues single-cycle accesses under a registered grant. Grants follow fixed-priority or round-robin policy with burst limiting and lock. Read data is broadcast with a per-port valid that tracks SRAM latency.

---
 rtl/sram_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// N-port arbiter in front of a single-port SRAM: fixed-priority or round-robin
// grants with burst limiting and lock, plus a read-tag pipeline driving rvalid.
module sram_port_arbiter #(
  parameter int N_PORTS    = 2,
  parameter int ADDR_BITS  = 16,
  parameter int DATA_BITS  = 8,
  parameter int RD_LATENCY = 1,
  parameter int ARB_MODE   = 0,
  parameter int MAX_BURST  = 16,
  localparam int OW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                           clk,
  input  logic                           aclr_n,
  input  logic [N_PORTS-1:0]             req,
  input  logic [N_PORTS-1:0]             lock,
  input  logic [N_PORTS-1:0]             we,
  input  logic [N_PORTS*ADDR_BITS-1:0]   addr,
  input  logic [N_PORTS*DATA_BITS-1:0]   wdata,
  output logic [N_PORTS-1:0]             gnt,
  output logic [DATA_BITS-1:0]           rdata,
  output logic [N_PORTS-1:0]             rvalid,
  output logic [OW-1:0]                  owner,
  output logic                           busy,
  output logic                           mem_we,
  output logic [ADDR_BITS-1:0]           mem_addr,
  output logic [DATA_BITS-1:0]           mem_wdata,
  input  logic [DATA_BITS-1:0]           mem_rdata
);

  typedef enum logic {IDLE, OWNED} state_e;

  localparam logic [N_PORTS-1:0] ONE = {{(N_PORTS-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [N_PORTS-1:0]   gnt_q, gnt_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [7:0]           burst_cnt_q, burst_cnt_d;
  logic [RD_LATENCY-1:0] tag_valid_q, tag_valid_d;
  logic [OW-1:0]        tag_port_q [RD_LATENCY];
  logic [OW-1:0]        tag_port_d [RD_LATENCY];

  logic                 accept, own_req, own_lock, grant_en;
  logic [OW-1:0]        winner;
  logic [8:0]           burst_next;
  logic [N_PORTS-1:0]   others;

  function automatic logic [OW-1:0] pick(input logic [N_PORTS-1:0] mask,
                                         input logic [OW-1:0] ptr);
    logic [OW-1:0] w;
    logic          found;
    int unsigned   idx;
    w     = '0;
    found = 1'b0;
    if (ARB_MODE == 0) begin
      for (int unsigned k = 0; k < N_PORTS; k++) begin
        if (!found && mask[k]) begin
          w     = OW'(k);
          found = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = 0; k < N_PORTS; k++) begin
        idx = (32'(ptr) + k) % 32'(N_PORTS);
        if (!found && mask[idx]) begin
          w     = OW'(idx);
          found = 1'b1;
        end
      end
    end
    return w;
  endfunction

  assign accept     = |(gnt_q & req);
  assign own_req    = req[owner_q];
  assign own_lock   = lock[owner_q];
  assign burst_next = {1'b0, burst_cnt_q} + {8'd0, accept};
  assign others     = req & ~gnt_q;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    grant_en    = 1'b0;
    winner      = '0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_en = 1'b1;
          winner   = pick(req, rr_ptr_q);
        end
      end
      OWNED: begin
        if (!own_lock && !own_req) begin
          if (|req) begin
            grant_en = 1'b1;
            winner   = pick(req, rr_ptr_q);
          end else begin
            state_d     = IDLE;
            gnt_d       = '0;
            owner_d     = '0;
            burst_cnt_d = '0;
          end
        end else if (!own_lock && accept && burst_next >= 9'(MAX_BURST)) begin
          // Burst limit: hand over to someone else if possible, else restart the tenure.
          grant_en = 1'b1;
          winner   = (|others) ? pick(others, rr_ptr_q) : owner_q;
        end else begin
          // Saturate so a long locked tenure cannot wrap back onto the limit.
          burst_cnt_d = burst_next[8] ? 8'hFF : burst_next[7:0];
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant_en) begin
      state_d     = OWNED;
      gnt_d       = ONE << winner;
      owner_d     = winner;
      burst_cnt_d = '0;
      rr_ptr_d    = (winner == OW'(N_PORTS - 1)) ? '0 : winner + 1'b1;
    end
  end

  always_comb begin
    tag_valid_d = '0;
    for (int unsigned s = 0; s < RD_LATENCY; s++) tag_port_d[s] = '0;
    tag_valid_d[0] = accept & ~we[owner_q];
    tag_port_d[0]  = owner_q;
    for (int unsigned s = 1; s < RD_LATENCY; s++) begin
      tag_valid_d[s] = tag_valid_q[s-1];
      tag_port_d[s]  = tag_port_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      tag_valid_q <= '0;
      for (int unsigned s = 0; s < RD_LATENCY; s++) tag_port_q[s] <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      tag_valid_q <= tag_valid_d;
      for (int unsigned s = 0; s < RD_LATENCY; s++) tag_port_q[s] <= tag_port_d[s];
    end
  end

  assign gnt       = gnt_q;
  assign owner     = owner_q;
  assign busy      = |gnt_q;
  assign rdata     = mem_rdata;
  assign rvalid    = tag_valid_q[RD_LATENCY-1] ? (ONE << tag_port_q[RD_LATENCY-1]) : '0;
  assign mem_we    = accept & we[owner_q];
  assign mem_addr  = accept ? addr[owner_q*ADDR_BITS +: ADDR_BITS] : '0;
  assign mem_wdata = accept ? wdata[owner_q*DATA_BITS +: DATA_BITS] : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: two configurations (3-port fixed priority, 4-port
// round-robin) compared each cycle against a transaction-level reference model.
module tb_sram_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic aclr_n;

  int compared;
  int mismatched;

  logic [3:0]  req_v  [2];
  logic [3:0]  lock_v [2];
  logic [3:0]  we_v   [2];
  logic [15:0] ad_v   [2][4];
  logic [7:0]  wd_v   [2][4];

  logic [2:0]  gnt_a, rvalid_a;
  logic [1:0]  owner_a;
  logic        busy_a, mem_we_a;
  logic [15:0] mem_addr_a;
  logic [7:0]  mem_wdata_a, mem_rdata_a, rdata_a;

  logic [3:0]  gnt_b, rvalid_b;
  logic [1:0]  owner_b;
  logic        busy_b, mem_we_b;
  logic [15:0] mem_addr_b;
  logic [7:0]  mem_wdata_b, mem_rdata_b, rdata_b;

  sram_port_arbiter #(.N_PORTS(3), .ADDR_BITS(16), .DATA_BITS(8), .RD_LATENCY(2),
                      .ARB_MODE(0), .MAX_BURST(4)) dut_a (
    .clk(clk), .aclr_n(aclr_n),
    .req(req_v[0][2:0]), .lock(lock_v[0][2:0]), .we(we_v[0][2:0]),
    .addr({ad_v[0][2], ad_v[0][1], ad_v[0][0]}),
    .wdata({wd_v[0][2], wd_v[0][1], wd_v[0][0]}),
    .gnt(gnt_a), .rdata(rdata_a), .rvalid(rvalid_a), .owner(owner_a), .busy(busy_a),
    .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_a)
  );

  sram_port_arbiter #(.N_PORTS(4), .ADDR_BITS(16), .DATA_BITS(8), .RD_LATENCY(1),
                      .ARB_MODE(1), .MAX_BURST(2)) dut_b (
    .clk(clk), .aclr_n(aclr_n),
    .req(req_v[1]), .lock(lock_v[1]), .we(we_v[1]),
    .addr({ad_v[1][3], ad_v[1][2], ad_v[1][1], ad_v[1][0]}),
    .wdata({wd_v[1][3], wd_v[1][2], wd_v[1][1], wd_v[1][0]}),
    .gnt(gnt_b), .rdata(rdata_b), .rvalid(rvalid_b), .owner(owner_b), .busy(busy_b),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b)
  );

  // SRAM models behind each arbiter (256 words, low address byte), cleared in reset.
  logic [7:0] sram [2][256];
  logic [7:0] rp_a0, rp_a1, rp_b;
  always @(posedge clk) begin
    if (!aclr_n) begin
      for (int k = 0; k < 256; k++) begin
        sram[0][k] <= '0;
        sram[1][k] <= '0;
      end
    end else begin
      if (mem_we_a) sram[0][mem_addr_a[7:0]] <= mem_wdata_a;
      if (mem_we_b) sram[1][mem_addr_b[7:0]] <= mem_wdata_b;
    end
    rp_a0 <= sram[0][mem_addr_a[7:0]];
    rp_a1 <= rp_a0;
    rp_b  <= sram[1][mem_addr_b[7:0]];
  end
  assign mem_rdata_a = rp_a1;
  assign mem_rdata_b = rp_b;

  logic [43:0] obs_a, obs_b;
  assign obs_a = {1'b0, gnt_a, owner_a, busy_a, mem_we_a, mem_addr_a, mem_wdata_a,
                  1'b0, rvalid_a, (|rvalid_a) ? rdata_a : 8'h00};
  assign obs_b = {gnt_b, owner_b, busy_b, mem_we_b, mem_addr_b, mem_wdata_b,
                  rvalid_b, (|rvalid_b) ? rdata_b : 8'h00};

  // Reference model state: ownership, tenure count, round-robin start, read tags, memory.
  bit          m_owned [2];
  int          m_own   [2];
  int          m_cnt   [2];
  int          m_rr    [2];
  int          m_tp    [2][2];
  logic [7:0]  m_td    [2][2];
  logic [7:0]  mmem    [2][256];
  logic [43:0] e_out   [2];

  function automatic int np(int i);   return (i == 0) ? 3 : 4; endfunction
  function automatic int lat(int i);  return (i == 0) ? 2 : 1; endfunction
  function automatic int mode(int i); return (i == 0) ? 0 : 1; endfunction
  function automatic int mb(int i);   return (i == 0) ? 4 : 2; endfunction

  function automatic int pick(int i, logic [3:0] mask);
    int n;
    int p;
    n = np(i);
    for (int k = 0; k < n; k++) begin
      p = (mode(i) == 0) ? k : (m_rr[i] + k) % n;
      if (mask[p]) return p;
    end
    return -1;
  endfunction

  function automatic logic [43:0] model_out(int i);
    int         o;
    bit         acc;
    logic [3:0] g, rv;
    logic [7:0] rd;
    o   = m_own[i];
    acc = m_owned[i] && req_v[i][o];
    g   = m_owned[i] ? 4'(1 << o) : 4'h0;
    rv  = (m_tp[i][lat(i)-1] >= 0) ? 4'(1 << m_tp[i][lat(i)-1]) : 4'h0;
    rd  = (rv != 4'h0) ? m_td[i][lat(i)-1] : 8'h00;
    return {g, 2'(o), m_owned[i], acc && we_v[i][o], acc ? ad_v[i][o] : 16'h0,
            acc ? wd_v[i][o] : 8'h00, rv, rd};
  endfunction

  task automatic model_commit(int i);
    int         o, n, nc, w;
    bit         acc, regrant;
    logic [3:0] oth;
    o   = m_own[i];
    n   = np(i);
    acc = m_owned[i] && req_v[i][o];
    for (int s = lat(i) - 1; s > 0; s--) begin
      m_tp[i][s] = m_tp[i][s-1];
      m_td[i][s] = m_td[i][s-1];
    end
    m_tp[i][0] = (acc && !we_v[i][o]) ? o : -1;
    m_td[i][0] = mmem[i][ad_v[i][o][7:0]];
    if (acc && we_v[i][o]) mmem[i][ad_v[i][o][7:0]] = wd_v[i][o];
    regrant = 1'b0;
    w       = -1;
    if (!m_owned[i]) begin
      w       = pick(i, req_v[i]);
      regrant = (w >= 0);
    end else begin
      nc = m_cnt[i] + (acc ? 1 : 0);
      if (!lock_v[i][o] && !req_v[i][o]) begin
        w       = pick(i, req_v[i]);
        regrant = (w >= 0);
        if (w < 0) begin
          m_owned[i] = 1'b0;
          m_own[i]   = 0;
        end
      end else if (!lock_v[i][o] && acc && nc >= mb(i)) begin
        oth     = req_v[i] & ~4'(1 << o);
        w       = pick(i, oth);
        if (w < 0) w = o;
        regrant = 1'b1;
      end else begin
        m_cnt[i] = (nc > 255) ? 255 : nc;
      end
    end
    if (regrant) begin
      m_owned[i] = 1'b1;
      m_own[i]   = w;
      m_cnt[i]   = 0;
      m_rr[i]    = (w + 1) % n;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_owned[i] = 1'b0;
      m_own[i]   = 0;
      m_cnt[i]   = 0;
      m_rr[i]    = 0;
      for (int s = 0; s < 2; s++) begin
        m_tp[i][s] = -1;
        m_td[i][s] = 8'h00;
      end
      for (int k = 0; k < 256; k++) mmem[i][k] = 8'h00;
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      req_v[i]  = '0;
      lock_v[i] = '0;
      we_v[i]   = '0;
      for (int p = 0; p < 4; p++) begin
        ad_v[i][p] = '0;
        wd_v[i][p] = '0;
      end
    end
  endtask

  task automatic rand_fields(int i, int max_addr);
    for (int p = 0; p < np(i); p++) begin
      we_v[i][p] = 1'($urandom_range(0, 1));
      ad_v[i][p] = 16'($urandom_range(0, max_addr));
      wd_v[i][p] = 8'($urandom);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    e_out[0] = model_out(0);
    e_out[1] = model_out(1);
  endtask

  task automatic step();
    model_commit(0);
    model_commit(1);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    aclr_n = 1'b0;
    clear_inputs();
    #2;
    compared++;
    if ({obs_a, obs_b} !== 88'h0) begin
      mismatched++;
      $display("FAIL reset_outputs got %h expected 0", {obs_a, obs_b});
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    aclr_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 1) req_v[0][0] = 1'b1;
      if (c == 3) req_v[0][0] = 1'b0;
      rand_fields(0, 31);
      settle();
      compared++;
      if ({obs_a, obs_b} !== {e_out[0], e_out[1]}) begin
        mismatched++;
        $display("FAIL reset_model t=%0t got %h expected %h", $time, {obs_a, obs_b}, {e_out[0], e_out[1]});
      end
      if (c == 1 || c == 2) begin
        compared++;
        if (gnt_a !== ((c == 2) ? 3'b001 : 3'b000)) begin
          mismatched++;
          $display("FAIL reset_first_grant c=%0d got %b expected %b", c, gnt_a, (c == 2) ? 3'b001 : 3'b000);
        end
      end
      step();
    end
  endtask

  task automatic test_fixed_priority();
    for (int c = 0; c < 6; c++) begin
      rand_fields(0, 31);
      we_v[0][1] = 1'b1;
      ad_v[0][1] = 16'h0010;
      wd_v[0][1] = 8'hA5;
      if (c == 0) req_v[0] = 4'b0110;
      if (c == 2) req_v[0][1] = 1'b0;
      if (c == 4) req_v[0] = 4'b0000;
      settle();
      compared++;
      if ({obs_a, obs_b} !== {e_out[0], e_out[1]}) begin
        mismatched++;
        $display("FAIL fixed_model t=%0t got %h expected %h", $time, {obs_a, obs_b}, {e_out[0], e_out[1]});
      end
      if (c == 1) begin
        compared++;
        if ({gnt_a, mem_we_a, mem_addr_a, mem_wdata_a} !== {3'b010, 1'b1, 16'h0010, 8'hA5}) begin
          mismatched++;
          $display("FAIL fixed_write got gnt=%b we=%b addr=%h data=%h expected gnt=010 we=1 addr=0010 data=a5",
                   gnt_a, mem_we_a, mem_addr_a, mem_wdata_a);
        end
      end
      if (c == 3) begin
        compared++;
        if ({gnt_a, mem_addr_a} !== {3'b100, ad_v[0][2]}) begin
          mismatched++;
          $display("FAIL fixed_handover got gnt=%b addr=%h expected gnt=100 addr=%h", gnt_a, mem_addr_a, ad_v[0][2]);
        end
      end
      step();
    end
  endtask

  task automatic test_read_latency();
    logic [7:0] got [8];
    int         n, first;
    n     = 0;
    first = -1;
    for (int c = 0; c < 13; c++) begin
      req_v[0][1] = (c <= 8);
      we_v[0][1]  = (c <= 4);
      ad_v[0][1]  = (c >= 1 && c <= 4) ? 16'(c - 1) : (c >= 5) ? 16'(c - 5) : 16'h0;
      wd_v[0][1]  = 8'(c * 8'h11);
      settle();
      compared++;
      if ({obs_a, obs_b} !== {e_out[0], e_out[1]}) begin
        mismatched++;
        $display("FAIL rdlat_model t=%0t got %h expected %h", $time, {obs_a, obs_b}, {e_out[0], e_out[1]});
      end
      if (rvalid_a[1] && n < 8) begin
        if (first < 0) first = c;
        got[n] = rdata_a;
        n++;
      end
      step();
    end
    compared++;
    if (n != 4 || first != 7) begin
      mismatched++;
      $display("FAIL rdlat_count got %0d beats from cycle %0d expected 4 beats from cycle 7", n, first);
    end
    for (int k = 0; k < 4 && k < n; k++) begin
      compared++;
      if (got[k] !== 8'((k + 1) * 8'h11)) begin
        mismatched++;
        $display("FAIL rdlat_data beat=%0d got %h expected %h", k, got[k], 8'((k + 1) * 8'h11));
      end
    end
  endtask

  task automatic test_reset_midburst();
    for (int c = 0; c < 5; c++) begin
      req_v[0][0] = 1'b1;
      req_v[1][3] = 1'b1;
      rand_fields(0, 31);
      rand_fields(1, 31);
      we_v[0][0] = 1'b0;
      we_v[1][3] = 1'b0;
      settle();
      compared++;
      if ({obs_a, obs_b} !== {e_out[0], e_out[1]}) begin
        mismatched++;
        $display("FAIL midrst_model t=%0t got %h expected %h", $time, {obs_a, obs_b}, {e_out[0], e_out[1]});
      end
      step();
    end
    aclr_n = 1'b0;
    clear_inputs();
    #1;
    compared++;
    if ({obs_a, obs_b} !== 88'h0) begin
      mismatched++;
      $display("FAIL midrst_outputs got %h expected 0", {obs_a, obs_b});
    end
    model_reset();
    @(posedge clk);
    #1;
    aclr_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 2) req_v[0][1] = 1'b1;
      if (c == 5) req_v[0][1] = 1'b0;
      rand_fields(0, 31);
      settle();
      compared++;
      if ({obs_a, obs_b} !== {e_out[0], e_out[1]}) begin
        mismatched++;
        $display("FAIL midrst_after t=%0t got %h expected %h", $time, {obs_a, obs_b}, {e_out[0], e_out[1]});
      end
      if (c < 3) begin
        compared++;
        if ({rvalid_a, rvalid_b} !== 7'h0) begin
          mismatched++;
          $display("FAIL midrst_rvalid c=%0d got %b expected 0", c, {rvalid_a, rvalid_b});
        end
      end
      if (c == 3) begin
        compared++;
        if (gnt_a !== 3'b010) begin
          mismatched++;
          $display("FAIL midrst_regrant got %b expected 010", gnt_a);
        end
      end
      step();
    end
  endtask

  task automatic test_round_robin();
    int eo;
    for (int c = 0; c < 14; c++) begin
      req_v[1] = (c <= 10) ? 4'hF : 4'h0;
      rand_fields(1, 31);
      settle();
      compared++;
      if ({obs_a, obs_b} !== {e_out[0], e_out[1]}) begin
        mismatched++;
        $display("FAIL rr_model t=%0t got %h expected %h", $time, {obs_a, obs_b}, {e_out[0], e_out[1]});
      end
      if (c >= 1 && c <= 10) begin
        eo = ((c - 1) / 2) % 4;
        compared++;
        if ({gnt_b, owner_b, mem_addr_b} !== {4'(1 << eo), 2'(eo), ad_v[1][eo]}) begin
          mismatched++;
          $display("FAIL rr_order c=%0d got gnt=%b owner=%0d addr=%h expected gnt=%b owner=%0d addr=%h",
                   c, gnt_b, owner_b, mem_addr_b, 4'(1 << eo), eo, ad_v[1][eo]);
        end
      end
      step();
    end
  endtask

  task automatic test_lock();
    for (int c = 0; c < 10; c++) begin
      req_v[1][0]  = (c <= 5);
      lock_v[1][0] = (c <= 5);
      req_v[1][1]  = (c >= 1 && c <= 7);
      rand_fields(1, 31);
      settle();
      compared++;
      if ({obs_a, obs_b} !== {e_out[0], e_out[1]}) begin
        mismatched++;
        $display("FAIL lock_model t=%0t got %h expected %h", $time, {obs_a, obs_b}, {e_out[0], e_out[1]});
      end
      if (c >= 1 && c <= 7) begin
        compared++;
        if (gnt_b !== ((c == 7) ? 4'b0010 : 4'b0001)) begin
          mismatched++;
          $display("FAIL lock_hold c=%0d got %b expected %b", c, gnt_b, (c == 7) ? 4'b0010 : 4'b0001);
        end
      end
      step();
    end
  endtask

  task automatic test_burst_lone();
    for (int c = 0; c < 13; c++) begin
      req_v[0][2] = (c <= 10);
      rand_fields(0, 31);
      settle();
      compared++;
      if ({obs_a, obs_b} !== {e_out[0], e_out[1]}) begin
        mismatched++;
        $display("FAIL lone_model t=%0t got %h expected %h", $time, {obs_a, obs_b}, {e_out[0], e_out[1]});
      end
      if (c >= 1 && c <= 10) begin
        compared++;
        if ({gnt_a, mem_addr_a, mem_we_a} !== {3'b100, ad_v[0][2], we_v[0][2]}) begin
          mismatched++;
          $display("FAIL lone_continuous c=%0d got gnt=%b addr=%h we=%b expected gnt=100 addr=%h we=%b",
                   c, gnt_a, mem_addr_a, mem_we_a, ad_v[0][2], we_v[0][2]);
        end
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 606; c++) begin
      for (int i = 0; i < 2; i++) begin
        for (int p = 0; p < np(i); p++) begin
          req_v[i][p]  = (c < 600) && ($urandom_range(0, 9) < 6);
          lock_v[i][p] = (c < 600) && ($urandom_range(0, 19) == 0);
        end
        rand_fields(i, 31);
      end
      settle();
      compared++;
      if ({obs_a, obs_b} !== {e_out[0], e_out[1]}) begin
        mismatched++;
        $display("FAIL random_model t=%0t got %h expected %h", $time, {obs_a, obs_b}, {e_out[0], e_out[1]});
      end
      step();
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_fixed_priority();
    test_read_latency();
    test_reset_midburst();
    test_round_robin();
    test_lock();
    test_burst_lone();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
